// File: rtl/sm_addsub_pipe.sv
// sm_addsub_pipe
//   Two-stage pipelined signed-magnitude adder/subtractor with an accumulator
//   mode, optional magnitude saturation and a zero flag.
//   Stage 1 latches the selected operands (a or acc), the effective operation
//   and the acc tag. Stage 2 is the output register.
//
// Parameters
//   W    word width; bit W-1 is the sign, W-2:0 the magnitude (W >= 3)
//   SAT  1 = saturate the magnitude on add overflow, 0 = wrap
// Ports
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    operand handshake (a, b, op, acc_mode)
//   acc_clr              pulse, sets acc to +0 (wins over an acc write)
//   out_valid/out_ready  result handshake (q, avf, e, zero)
//   acc                  accumulator value
module sm_addsub_pipe #(
  parameter int W   = 32,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  input  logic         acc_mode,
  input  logic         acc_clr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] q,
  output logic         avf,
  output logic         e,
  output logic         zero,
  output logic [W-1:0] acc
);
  localparam int STAGES = 2;
  localparam int MW     = W - 1;
  localparam logic [MW-1:0] M_ONE = {{(MW-1){1'b0}}, 1'b1};
  localparam logic [MW:0]   W_ONE = {{MW{1'b0}}, 1'b1};

  // Stage-1 payload: the b sign and op are folded into the effective-subtract bit.
  typedef struct packed {
    logic          sa;
    logic [MW-1:0] ma;
    logic [MW-1:0] mb;
    logic          sub;
    logic          acc;
  } s1_t;

  logic [STAGES:1] vld_pipe;
  s1_t             s1;
  logic            adv, accept, acc_busy;
  logic [W-1:0]    a_sel;

  assign out_valid = vld_pipe[STAGES];
  assign adv       = !vld_pipe[STAGES] | out_ready;
  // An acc op in S1 has not written acc yet; a second acc op must wait one cycle.
  assign acc_busy  = vld_pipe[1] & s1.acc;
  assign in_ready  = rst_n & adv & !(acc_mode & acc_busy);
  assign accept    = in_valid & in_ready;
  assign a_sel     = acc_mode ? acc : a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1       <= '0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], accept};
      if (accept) begin
        s1.sa  <= a_sel[W-1];
        s1.ma  <= a_sel[MW-1:0];
        s1.mb  <= b[MW-1:0];
        s1.sub <= a_sel[W-1] ^ b[W-1] ^ op;
        s1.acc <= acc_mode;
      end
    end
  end

  // Stage-2 combinational datapath
  logic [MW:0]   sum_add, sum_sub;
  logic [MW-1:0] mag;
  logic          sgn, cy, ovf, z;
  logic [W-1:0]  res;

  assign sum_add = {1'b0, s1.ma} + {1'b0, s1.mb};
  assign sum_sub = {1'b0, s1.ma} + {1'b0, ~s1.mb} + W_ONE;

  always_comb begin
    mag = '0;
    sgn = 1'b0;
    cy  = 1'b0;
    ovf = 1'b0;
    if (!s1.sub) begin
      cy  = sum_add[MW];
      ovf = sum_add[MW];
      sgn = s1.sa;
      mag = (sum_add[MW] && SAT) ? '1 : sum_add[MW-1:0];
    end else begin
      cy = sum_sub[MW];
      // No carry means |B| > |A|: take the two's complement and flip the sign.
      if (sum_sub[MW]) begin
        mag = sum_sub[MW-1:0];
        sgn = s1.sa;
      end else begin
        mag = ~sum_sub[MW-1:0] + M_ONE;
        sgn = ~s1.sa;
      end
    end
  end

  assign z   = (mag == '0);
  assign res = {sgn & ~z, mag};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      avf  <= 1'b0;
      e    <= 1'b0;
      zero <= 1'b0;
    end else if (adv && vld_pipe[1]) begin
      q    <= res;
      avf  <= ovf;
      e    <= cy;
      zero <= z;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             acc <= '0;
    else if (acc_clr)                       acc <= '0;
    else if (adv && vld_pipe[1] && s1.acc)  acc <= res;
  end
endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Bench for sm_addsub_pipe: a wrapping (SAT=0) and a saturating (SAT=1)
// instance share one stimulus stream. Directed vector table plus scripted
// backpressure, accumulate, clear-collision and reset sequences.
module tb_sm_addsub_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, op = 1'b0, acc_mode = 1'b0, acc_clr = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic        in_ready, out_valid, avf, e, zero;
  logic [31:0] q, acc;
  logic        in_ready_s, out_valid_s, avf_s, e_s, zero_s;
  logic [31:0] q_s, acc_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sm_addsub_pipe #(.W(32), .SAT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_mode(acc_mode), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .q(q), .avf(avf), .e(e),
    .zero(zero), .acc(acc));

  sm_addsub_pipe #(.W(32), .SAT(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .a(a), .b(b), .op(op), .acc_mode(acc_mode), .acc_clr(acc_clr),
    .out_valid(out_valid_s), .out_ready(out_ready), .q(q_s), .avf(avf_s), .e(e_s),
    .zero(zero_s), .acc(acc_s));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic        op;
    logic [31:0] q;
    logic        e, avf, zero;
    logic [31:0] q_sat;
    logic        zero_sat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          seen, stall, bi;
    logic [31:0] held, prev_acc;
    logic [31:0] got[$];
    logic [31:0] accs[$];
    logic        last_acc, any_vld;

    //          a             b             op    q             e     avf   zero  q_sat         zero_sat
    vecs[0] = '{32'h00000005, 32'h80000003, 1'b0, 32'h00000002, 1'b1, 1'b0, 1'b0, 32'h00000002, 1'b0};
    vecs[1] = '{32'h00000003, 32'h00000005, 1'b1, 32'h80000002, 1'b0, 1'b0, 1'b0, 32'h80000002, 1'b0};
    vecs[2] = '{32'h80000007, 32'h00000007, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 32'h00000000, 1'b1};
    vecs[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b0};
    vecs[4] = '{32'h00000000, 32'h80000000, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1, 32'h00000000, 1'b1};
    vecs[5] = '{32'h80000005, 32'h80000003, 1'b0, 32'h80000008, 1'b0, 1'b0, 1'b0, 32'h80000008, 1'b0};
    vecs[6] = '{32'h80000005, 32'h80000009, 1'b1, 32'h00000004, 1'b0, 1'b0, 1'b0, 32'h00000004, 1'b0};
    vecs[7] = '{32'h80000010, 32'h00000004, 1'b0, 32'h8000000C, 1'b1, 1'b0, 1'b0, 32'h8000000C, 1'b0};
    vecs[8] = '{32'hFFFFFFFF, 32'h80000002, 1'b0, 32'h80000001, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0};
    vecs[9] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 32'h00000000, 1'b1};

    // Reset state
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_q", q, 0);
    chk("rst_flags", {avf, e, zero}, 0);
    chk("rst_acc", acc, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, one at a time
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = vecs[i].a; b = vecs[i].b; op = vecs[i].op;
      #1 chk($sformatf("v%0d_in_ready", i), in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      #1 chk($sformatf("v%0d_early_valid", i), out_valid, 0);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), out_valid, 1);
      chk($sformatf("v%0d_q", i), q, vecs[i].q);
      chk($sformatf("v%0d_e_avf_zero", i), {e, avf, zero}, {vecs[i].e, vecs[i].avf, vecs[i].zero});
      chk($sformatf("v%0d_q_sat", i), q_s, vecs[i].q_sat);
      chk($sformatf("v%0d_zero_sat", i), {avf_s, zero_s}, {vecs[i].avf, vecs[i].zero_sat});
    end
    chk("plain_acc_untouched", acc, 0);

    // Backpressure: 4 beats, out_ready low for 3 cycles from the first result
    bi = 0; seen = 0; stall = 0; held = '0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      in_valid = (bi < 4); a = 32'(bi + 1); b = 32'h80000001; op = 1'b1;
      if (out_valid && seen == 0) begin seen = 1; stall = 3; held = q; end
      out_ready = (stall == 0);
      #1;
      if (stall > 0) begin
        chk("bp_in_ready", in_ready, 0);
        chk("bp_q_stable", q, held);
        chk("bp_valid_hold", out_valid, 1);
        stall--;
      end
      if (out_valid && out_ready) got.push_back(q);
      if (in_valid && in_ready) bi++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_count", got.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("bp_res%0d", i), (i < got.size()) ? got[i] : 32'hXXXXXXXX, 32'(i + 2));

    // Accumulate: clear, then 3 back-to-back acc beats of +10
    @(negedge clk);
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    #1 chk("acc_cleared", acc, 0);
    bi = 0; last_acc = 1'b0; prev_acc = acc;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      in_valid = (bi < 3); acc_mode = 1'b1; a = 32'h0000DEAD; b = 32'h0000000A; op = 1'b0;
      #1;
      if (last_acc) chk("acc_stall", in_ready, 0);
      last_acc = in_valid && in_ready;
      if (in_valid && in_ready) begin
        chk($sformatf("acc_accept_cyc%0d", bi), cyc, 2 * bi);
        bi++;
      end
      if (acc !== prev_acc) begin accs.push_back(acc); prev_acc = acc; end
    end
    chk("acc_updates", accs.size(), 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("acc_val%0d", i), (i < accs.size()) ? accs[i] : 32'hXXXXXXXX, 32'(10 * (i + 1)));

    @(negedge clk);
    in_valid = 1'b1; acc_mode = 1'b1; b = 32'h00000028; op = 1'b0;
    #1 chk("acc4_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("acc4_q", q, 32'h00000046);
    chk("acc4_acc", acc, 32'h00000046);

    // Clear collides with the accumulator write
    @(negedge clk);
    in_valid = 1'b1; acc_mode = 1'b1; b = 32'h00000002; op = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    #1;
    chk("clr_acc", acc, 0);
    chk("clr_q", q, 32'h00000048);
    chk("clr_valid", out_valid, 1);

    // Reset with two beats in flight
    @(negedge clk);
    in_valid = 1'b1; acc_mode = 1'b1; b = 32'h00000005; op = 1'b0;
    @(negedge clk);
    acc_mode = 1'b0; a = 32'h00000001; b = 32'h00000001;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_rst_acc", acc, 5);
    chk("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_acc", acc, 0);
    chk("mid_rst_q", q, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    any_vld = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      #1 if (out_valid) any_vld = 1'b1;
    end
    chk("post_rst_no_ghost", any_vld, 0);

    @(negedge clk);
    in_valid = 1'b1; a = 32'h00000009; b = 32'h00000001; op = 1'b0;
    #1 chk("post_rst_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_q", q, 32'h0000000A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sm_addsub_pipe.md
# sm_addsub_pipe

Parametrised, pipelined signed-magnitude adder/subtractor. It is the successor of the single-cycle 32-bit signed-magnitude add/sub datapath. Width is generic, and the block adds a valid/ready handshake on both sides, an internal accumulator mode, optional saturation on magnitude overflow, and a zero flag. It sits between the operand register file and the result bus of the arithmetic unit, with a 2-cycle latency and a throughput of one operation per cycle.

## Interface
- W, 32, total word width; bit W-1 is the sign, bits W-2:0 are the magnitude (W ≥ 3)
- SAT, 0, 1 = on overflow the magnitude saturates to all ones; 0 = the magnitude wraps (truncated sum)
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  operand beat present
- in_ready  out  1  block accepts the beat this cycle
- a  in  W  signed-magnitude operand A
- b  in  W  signed-magnitude operand B
- op  in  1  0 = A+B, 1 = A−B
- acc_mode  in  1  1 = use the accumulator in place of a; the result is written back to the accumulator
- acc_clr  in  1  single-cycle pulse; sets the accumulator to +0
- out_valid  out  1  result present
- out_ready  in  1  consumer takes the result
- q  out  W  signed-magnitude result
- avf  out  1  magnitude overflow (effective add only)
- e  out  1  carry out of the magnitude adder
- zero  out  1  result magnitude is 0 (q is forced to +0)
- acc  out  W  current accumulator value

## Operation
- **Effective operation:** sb_eff = b[W-1]^op; s = a_sel[W-1]^sb_eff, where a_sel is a, or acc when acc_mode=1.
- **s=0 (effective add):**
  - {c, m} = |A| + |B| at W bits (W-1-bit magnitudes plus carry).
  - e=c, avf=c.
  - Sign = A sign.
  - When c=1 and SAT=1, the magnitude is all ones.
- **s=1 (effective subtract):**
  - {c, d} = |A| + ~|B| + 1.
  - e=c, avf=0.
  - c=1: magnitude = d, sign = A sign.
  - c=0: magnitude = ~d + 1, sign = ~A sign.
- **Zero result:** sign is forced to 0 and zero=1. This applies to any zero magnitude, including effective add of +0 and −0.
- **Negative-zero inputs** are treated as magnitude 0, with no special case.
- **Pipeline stages:**
  - S1 registers the selected operands, the effective op and the acc_mode tag.
  - S2 registers q/avf/e/zero.
  - S2 is the output register.
- **Accumulator:**
  - Written with the S2 result on the same edge S2 loads an acc_mode op.
  - Plain ops never modify the accumulator.
  - acc_clr on the same edge as an accumulator write: clear wins, acc=+0. The S2 result still appears on q.
- **Accumulator hazard:** an acc_mode beat is not accepted while S1 holds an acc_mode op. The stall is 1 cycle, so back-to-back accumulate ops run at 1 op per 2 cycles. Plain ops are never stalled by this rule.

## Timing
- **Reset values** (immediate on rst_n low): in_ready=0 while rst_n=0; out_valid=0, q=0, avf=0, e=0, zero=0, acc=0. All S1/S2 valid bits are 0.
- **Reset mid-operation:** all in-flight beats are discarded; none emerge after reset is released.
- in_ready=1 is permitted in the first cycle after release.
- **Accept** occurs on an edge with in_valid & in_ready.
- **Latency:** the result shows out_valid=1 exactly 2 edges after accept, when there is no backpressure.
- **Advance:** adv = !out_valid | out_ready.
  - S2 loads from S1 when adv.
  - S1 loads when adv.
  - in_ready = adv & !(acc_mode & S1.valid & S1.acc).
  - in_ready may depend combinationally on out_ready and acc_mode.
- **Backpressure:** while out_valid & !out_ready, q/avf/e/zero/out_valid hold stable. S1 holds and nothing is accepted.
- A result is consumed on an edge with out_valid & out_ready. On the same edge, S1 moves to S2 and a new beat enters S1, which gives full throughput.
- acc is registered, and updates 1 edge after S1 holds the acc op (same edge as out_valid rises for that op).

## Test plan
- **Basic add/sub cases** (W=32, SAT=0, no backpressure):
  - a=0x00000005, b=0x80000003, op=0 → q=0x00000002, e=1, avf=0, zero=0, 2 cycles after accept.
  - a=0x00000003, b=0x00000005, op=1 → q=0x80000002, e=0, avf=0.
  - a=0x80000007, b=0x00000007, op=0 → q=0x00000000, zero=1, e=1.
- **Overflow:**
  - a=0x7FFFFFFF, b=0x00000001, op=0 → q=0x00000000, avf=1, e=1, zero=1 with SAT=0.
  - The same stimulus with SAT=1 → q=0x7FFFFFFF, avf=1, zero=0.
- **Backpressure:** stream 4 beats (a=1..4, b=0x80000001, op=1). Hold out_ready=0 for 3 cycles after the first out_valid.
  - Results 2, 3, 4, 5 arrive in order with none lost or duplicated.
  - q stays stable while stalled.
  - in_ready=0 during the stall.
- **Accumulate:**
  - acc_clr, then 3 consecutive acc_mode beats with b=0x0000000A, op=0 → acc=0x0000000A, 0x00000014, 0x0000001E.
  - in_ready drops for 1 cycle between each beat.
  - Then acc_mode with b=0x00000028, op=0 → q=0x00000046.
- **Clear collision:** assert acc_clr on the edge an acc op writes → acc=0x00000000, and q still shows that op's result.
- **Reset mid-operation:** rst_n low for 1 cycle with 2 beats in flight → out_valid=0 and acc=0 immediately. No results emerge afterwards, and the next beat completes normally.
